dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Load/store initiator that drives the byte-addressed data memory port:
  - read address, sampled on the clock edge, data combinational in the following cycle;
  - write address, data and write enable, committed on the clock edge.
- Sits between the core's memory stage and data memory.
- Converts word/byte load and store requests into memory cycles, including read-modify-write for byte stores.
- Returns one response per request.

Parameters:
- WORD_WIDTH, 16, data word width; must be 16 (two bytes per word).
- ADDR_WIDTH, 12, byte address width; bit 0 selects the byte within a word.

Ports:
- clock  in  1  single clock, all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- in_req_valid  in  1  request present.
- out_req_ready  out  1  request accepted on a posedge where valid && ready.
- in_req_write  in  1  1 = store, 0 = load.
- in_req_byte  in  1  1 = byte access, 0 = word access.
- in_req_signed  in  1  byte load: 1 = sign-extend, 0 = zero-extend.
- in_req_addr  in  ADDR_WIDTH  byte address.
- in_req_wdata  in  WORD_WIDTH  store data; byte store uses bits 7:0.
- out_rsp_valid  out  1  one-cycle response pulse.
- out_rsp_rdata  out  WORD_WIDTH  load result; 0 for stores and errors.
- out_rsp_err  out  1  misaligned word access, valid with out_rsp_valid.
- out_mem_addr_rd  out  ADDR_WIDTH  memory read address.
- out_mem_addr_wr  out  ADDR_WIDTH  memory write address.
- out_mem_word  out  WORD_WIDTH  memory write data.
- out_mem_write_en  out  1  memory write strobe.
- in_mem_word  in  WORD_WIDTH  memory read data; valid the cycle after the address is sampled.

Behaviour:
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- Reset values (async, while reset_n = 0):
  - state = IDLE;
  - out_rsp_valid = 0, out_rsp_err = 0, out_mem_write_en = 0;
  - out_rsp_rdata = 0, out_mem_word = 0, out_mem_addr_wr = 0.
- out_req_ready = 1 in IDLE and RESP, 0 otherwise. An accept in RESP chains directly into the next state.
- Read address path:
  - When ready, out_mem_addr_rd = in_req_addr (combinational), so memory samples it at the accept edge.
  - Otherwise out_mem_addr_rd holds the registered request address.
- Request latched at the accept edge: address, data, byte, signed.
- Misaligned word access (in_req_byte = 0, addr[0] = 1):
  - go to RESP with err = 1, rdata = 0;
  - no write strobe.
- Word load: accept (E0) -> LOAD -> RESP.
  - In LOAD, in_mem_word is captured at E1.
  - out_rsp_valid is high the cycle after E1.
- Byte load: same timing as word load.
  - Byte lane: addr[0] = 0 selects bits 7:0, addr[0] = 1 selects bits 15:8 (little-endian).
  - Extension: sign or zero per latched signed flag.
- Word store: accept -> STORE -> RESP.
  - In STORE: out_mem_write_en = 1, out_mem_addr_wr = latched address, out_mem_word = latched data.
  - Memory commits at E1; response the cycle after, with rdata = 0.
- Byte store: accept -> RMW_RD -> RMW_WR -> RESP.
  - In RMW_RD: merge in_mem_word with the latched byte in the selected lane; register the result at E1.
  - In RMW_WR: write_en = 1; commit at E2.
- out_mem_write_en is high only in STORE and RMW_WR.
- RESP lasts exactly one cycle; there is no response backpressure.
- Back-to-back: a load accepted in RESP directly after a store observes the stored value, because the write committed before the read is sampled.
- Reset mid-operation: state returns to IDLE immediately and write_en drops asynchronously. A pending RMW write is discarded and no response is issued.
- Address wrap: highest word address accessed normally; no wrap logic needed.

Optional Feature:
- Macro: DMEM_LSU_STATS_EN.
- When defined, three extra outputs are added:
  - out_stat_loads, 16 bits;
  - out_stat_stores, 16 bits;
  - out_stat_errs, 16 bits.
- Counter rules:
  - reset to 0;
  - each increments once per response of its class;
  - saturating at 16'hFFFF.
- When undefined: no such ports or logic; behaviour otherwise identical.

Test Plan:
- Memory word 0x010 = 16'hA5C3; word load addr 0x010 -> rsp_valid 2 cycles after accept, rdata = 16'hA5C3, err = 0.
- Same word; signed byte load addr 0x011 -> rdata = 16'hFFA5; unsigned byte load addr 0x010 -> rdata = 16'h00C3.
- Byte store wdata 16'h0077 to addr 0x011 over 16'hA5C3 -> one write_en pulse in RMW_WR; memory = 16'h77C3; response 3 cycles after accept.
- Word store 16'h1234 to 0x020 accepted, then load 0x020 accepted in RESP cycle -> rdata = 16'h1234.
- Word load addr 0x013 -> rsp_valid next cycle, err = 1, rdata = 0, no write_en.
- reset_n low during RMW_RD of a byte store -> no write_en pulse, memory unchanged, no rsp_valid; ready = 1 after release.

Source files
------------

// File: rtl/dmem_lsu.sv
// Load/store unit bridging the core memory stage to a byte-addressed data memory (sync read, sync write).
// Optional DMEM_LSU_STATS_EN adds saturating load/store/error response counters.
//
// state  | meaning
// IDLE   | ready, no request in flight
// LOAD   | memory returns the word sampled at the accept edge
// STORE  | word write strobe asserted, commits at the next edge
// RMW_RD | old word returned, merged with the store byte
// RMW_WR | merged word write strobe asserted
// RESP   | one-cycle response; a new request may be accepted here
module dmem_lsu #(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_req_valid,
  output logic                  out_req_ready,
  input  logic                  in_req_write,
  input  logic                  in_req_byte,
  input  logic                  in_req_signed,
  input  logic [ADDR_WIDTH-1:0] in_req_addr,
  input  logic [WORD_WIDTH-1:0] in_req_wdata,
  output logic                  out_rsp_valid,
  output logic [WORD_WIDTH-1:0] out_rsp_rdata,
  output logic                  out_rsp_err,
  output logic [ADDR_WIDTH-1:0] out_mem_addr_rd,
  output logic [ADDR_WIDTH-1:0] out_mem_addr_wr,
  output logic [WORD_WIDTH-1:0] out_mem_word,
  output logic                  out_mem_write_en,
  input  logic [WORD_WIDTH-1:0] in_mem_word
`ifdef DMEM_LSU_STATS_EN
  ,
  output logic [15:0]           out_stat_loads,
  output logic [15:0]           out_stat_stores,
  output logic [15:0]           out_stat_errs
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              wbyte_q;
  logic                    byte_q;
  logic                    signed_q;
  logic                    write_q;
  logic                    misaligned;
  logic [7:0]              lane;
  logic [WORD_WIDTH-1:0]   load_data;
  logic [WORD_WIDTH-1:0]   merge_data;

  assign out_req_ready   = (state == IDLE) || (state == RESP);
  // Memory samples the read address at the accept edge, so it must bypass the request register.
  assign out_mem_addr_rd = out_req_ready ? in_req_addr : addr_q;
  assign misaligned      = !in_req_byte && in_req_addr[0];

  assign lane       = addr_q[0] ? in_mem_word[15:8] : in_mem_word[7:0];
  assign load_data  = byte_q ? {{8{signed_q & lane[7]}}, lane} : in_mem_word;
  assign merge_data = addr_q[0] ? {wbyte_q, in_mem_word[7:0]} : {in_mem_word[15:8], wbyte_q};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      addr_q           <= '0;
      wbyte_q          <= '0;
      byte_q           <= 1'b0;
      signed_q         <= 1'b0;
      write_q          <= 1'b0;
      out_rsp_valid    <= 1'b0;
      out_rsp_err      <= 1'b0;
      out_rsp_rdata    <= '0;
      out_mem_write_en <= 1'b0;
      out_mem_word     <= '0;
      out_mem_addr_wr  <= '0;
    end else begin
      out_rsp_valid    <= 1'b0;
      out_rsp_err      <= 1'b0;
      out_rsp_rdata    <= '0;
      out_mem_write_en <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (in_req_valid) begin
            addr_q   <= in_req_addr;
            wbyte_q  <= in_req_wdata[7:0];
            byte_q   <= in_req_byte;
            signed_q <= in_req_signed;
            write_q  <= in_req_write;
            if (misaligned) begin
              state         <= RESP;
              out_rsp_valid <= 1'b1;
              out_rsp_err   <= 1'b1;
            end else if (!in_req_write) begin
              state <= LOAD;
            end else if (in_req_byte) begin
              state <= RMW_RD;
            end else begin
              state            <= STORE;
              out_mem_write_en <= 1'b1;
              out_mem_addr_wr  <= in_req_addr;
              out_mem_word     <= in_req_wdata;
            end
          end else begin
            state <= IDLE;
          end
        end
        LOAD: begin
          state         <= RESP;
          out_rsp_valid <= 1'b1;
          out_rsp_rdata <= load_data;
        end
        STORE: begin
          state         <= RESP;
          out_rsp_valid <= 1'b1;
        end
        RMW_RD: begin
          state            <= RMW_WR;
          out_mem_write_en <= 1'b1;
          out_mem_addr_wr  <= addr_q;
          out_mem_word     <= merge_data;
        end
        RMW_WR: begin
          state         <= RESP;
          out_rsp_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_LSU_STATS_EN
  // Counted while the response is presented; write_q still describes that response here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_stat_loads  <= '0;
      out_stat_stores <= '0;
      out_stat_errs   <= '0;
    end else if (out_rsp_valid) begin
      if (out_rsp_err) begin
        if (out_stat_errs != 16'hFFFF) out_stat_errs <= out_stat_errs + 16'd1;
      end else if (write_q) begin
        if (out_stat_stores != 16'hFFFF) out_stat_stores <= out_stat_stores + 16'd1;
      end else begin
        if (out_stat_loads != 16'hFFFF) out_stat_loads <= out_stat_loads + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu against a simple sync-read/sync-write word memory model.
module tb_dmem_lsu;
  logic        clock;
  logic        reset_n;
  logic        in_req_valid;
  logic        out_req_ready;
  logic        in_req_write;
  logic        in_req_byte;
  logic        in_req_signed;
  logic [11:0] in_req_addr;
  logic [15:0] in_req_wdata;
  logic        out_rsp_valid;
  logic [15:0] out_rsp_rdata;
  logic        out_rsp_err;
  logic [11:0] out_mem_addr_rd;
  logic [11:0] out_mem_addr_wr;
  logic [15:0] out_mem_word;
  logic        out_mem_write_en;
  logic [15:0] in_mem_word;
`ifdef DMEM_LSU_STATS_EN
  logic [15:0] out_stat_loads;
  logic [15:0] out_stat_stores;
  logic [15:0] out_stat_errs;
`endif

  logic [15:0] mem [0:2047];
  logic [11:0] rd_q;
  logic        bd_we;
  logic [11:0] bd_addr;
  logic [15:0] bd_data;

  int n_cmp = 0;
  int n_err = 0;

  dmem_lsu #(.WORD_WIDTH(16), .ADDR_WIDTH(12)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_req_valid(in_req_valid), .out_req_ready(out_req_ready),
    .in_req_write(in_req_write), .in_req_byte(in_req_byte),
    .in_req_signed(in_req_signed), .in_req_addr(in_req_addr),
    .in_req_wdata(in_req_wdata), .out_rsp_valid(out_rsp_valid),
    .out_rsp_rdata(out_rsp_rdata), .out_rsp_err(out_rsp_err),
    .out_mem_addr_rd(out_mem_addr_rd), .out_mem_addr_wr(out_mem_addr_wr),
    .out_mem_word(out_mem_word), .out_mem_write_en(out_mem_write_en),
    .in_mem_word(in_mem_word)
`ifdef DMEM_LSU_STATS_EN
    , .out_stat_loads(out_stat_loads), .out_stat_stores(out_stat_stores),
    .out_stat_errs(out_stat_errs)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) begin
    if (bd_we) mem[bd_addr[11:1]] <= bd_data;
    else if (out_mem_write_en) mem[out_mem_addr_wr[11:1]] <= out_mem_word;
    rd_q <= out_mem_addr_rd;
  end
  assign in_mem_word = mem[rd_q[11:1]];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [15:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clock); #1;
    bd_we = 1'b0;
  endtask

  task automatic send(input logic w, input logic b, input logic s,
                      input logic [11:0] a, input logic [15:0] d);
    in_req_valid = 1'b1; in_req_write = w; in_req_byte = b;
    in_req_signed = s; in_req_addr = a; in_req_wdata = d;
    #1;
    check_eq("ready_at_send", {31'd0, out_req_ready}, 32'd1);
    check_eq("addr_rd_bypass", {20'd0, out_mem_addr_rd}, {20'd0, a});
    @(posedge clock); #1;
    in_req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc, output logic [15:0] rd, output logic er,
                          output int wen);
    cyc = 1; wen = 0;
    while (!out_rsp_valid && cyc < 10) begin
      wen += int'(out_mem_write_en);
      @(posedge clock); #1;
      cyc++;
    end
    wen += int'(out_mem_write_en);
    check_eq("rsp_seen", {31'd0, out_rsp_valid}, 32'd1);
    rd = out_rsp_rdata;
    er = out_rsp_err;
  endtask

  int          cyc, wen, bad_wen, bad_rsp;
  logic [15:0] rd;
  logic        er;

  initial begin
    reset_n = 1'b0; in_req_valid = 1'b0; in_req_write = 1'b0; in_req_byte = 1'b0;
    in_req_signed = 1'b0; in_req_addr = '0; in_req_wdata = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_rsp_valid", {31'd0, out_rsp_valid}, 32'd0);
    check_eq("rst_rsp_err", {31'd0, out_rsp_err}, 32'd0);
    check_eq("rst_write_en", {31'd0, out_mem_write_en}, 32'd0);
    check_eq("rst_rdata", {16'd0, out_rsp_rdata}, 32'd0);
    check_eq("rst_mem_word", {16'd0, out_mem_word}, 32'd0);
    check_eq("rst_addr_wr", {20'd0, out_mem_addr_wr}, 32'd0);
    check_eq("rst_ready", {31'd0, out_req_ready}, 32'd1);
    poke(12'h010, 16'hA5C3);
    poke(12'h020, 16'h0000);
    poke(12'h030, 16'hBEEF);
    reset_n = 1'b1;
    @(posedge clock); #1;

    send(1'b0, 1'b0, 1'b0, 12'h010, 16'h0);
    wait_rsp(cyc, rd, er, wen);
    check_eq("wload_lat", cyc, 2);
    check_eq("wload_data", {16'd0, rd}, 32'h0000A5C3);
    check_eq("wload_err", {31'd0, er}, 32'd0);
    check_eq("wload_wen", wen, 0);

    send(1'b0, 1'b1, 1'b1, 12'h011, 16'h0);
    wait_rsp(cyc, rd, er, wen);
    check_eq("bload_s_lat", cyc, 2);
    check_eq("bload_s_data", {16'd0, rd}, 32'h0000FFA5);

    send(1'b0, 1'b1, 1'b0, 12'h010, 16'h0);
    wait_rsp(cyc, rd, er, wen);
    check_eq("bload_u_data", {16'd0, rd}, 32'h000000C3);

    send(1'b1, 1'b1, 1'b0, 12'h011, 16'h0077);
    wait_rsp(cyc, rd, er, wen);
    check_eq("bstore_lat", cyc, 3);
    check_eq("bstore_wen", wen, 1);
    check_eq("bstore_rdata", {16'd0, rd}, 32'd0);
    check_eq("bstore_mem", {16'd0, mem[12'h010 >> 1]}, 32'h000077C3);

    send(1'b0, 1'b1, 1'b1, 12'h010, 16'h0);
    wait_rsp(cyc, rd, er, wen);
    check_eq("bload_lo_s", {16'd0, rd}, 32'h0000FFC3);

    send(1'b0, 1'b1, 1'b0, 12'h011, 16'h0);
    wait_rsp(cyc, rd, er, wen);
    check_eq("bload_hi_u", {16'd0, rd}, 32'h00000077);

    send(1'b1, 1'b0, 1'b0, 12'h020, 16'h1234);
    wait_rsp(cyc, rd, er, wen);
    check_eq("wstore_lat", cyc, 2);
    check_eq("wstore_wen", wen, 1);
    check_eq("wstore_mem", {16'd0, mem[12'h020 >> 1]}, 32'h00001234);
    send(1'b0, 1'b0, 1'b0, 12'h020, 16'h0);
    wait_rsp(cyc, rd, er, wen);
    check_eq("b2b_lat", cyc, 2);
    check_eq("b2b_data", {16'd0, rd}, 32'h00001234);

    send(1'b0, 1'b0, 1'b0, 12'h013, 16'h0);
    wait_rsp(cyc, rd, er, wen);
    check_eq("mis_ld_lat", cyc, 1);
    check_eq("mis_ld_err", {31'd0, er}, 32'd1);
    check_eq("mis_ld_rdata", {16'd0, rd}, 32'd0);
    check_eq("mis_ld_wen", wen, 0);

    send(1'b1, 1'b0, 1'b0, 12'h021, 16'hFFFF);
    wait_rsp(cyc, rd, er, wen);
    check_eq("mis_st_err", {31'd0, er}, 32'd1);
    check_eq("mis_st_wen", wen, 0);
    check_eq("mis_st_mem", {16'd0, mem[12'h020 >> 1]}, 32'h00001234);

    @(posedge clock); #1;
    send(1'b1, 1'b1, 1'b0, 12'h031, 16'h0055);
    reset_n = 1'b0;
    #1;
    bad_wen = int'(out_mem_write_en);
    bad_rsp = int'(out_rsp_valid);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      bad_wen += int'(out_mem_write_en);
      bad_rsp += int'(out_rsp_valid);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      bad_wen += int'(out_mem_write_en);
      bad_rsp += int'(out_rsp_valid);
    end
    check_eq("rstmid_wen", bad_wen, 0);
    check_eq("rstmid_rsp", bad_rsp, 0);
    check_eq("rstmid_mem", {16'd0, mem[12'h030 >> 1]}, 32'h0000BEEF);
    check_eq("rstmid_ready", {31'd0, out_req_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
